// File: rtl/traffic_phase_controller.sv
// Timed N-approach intersection controller: green/yellow/all-red cycling with latched pedestrian WALK service.
// Optional night flashing-yellow mode is compiled in with NIGHT_FLASH_EN.
module traffic_phase_controller #(
   parameter int N_PHASE  = 2,
   parameter int CNT_W    = 8,
   parameter int GREEN_T  = 20,
   parameter int YELLOW_T = 4,
   parameter int CLEAR_T  = 2,
   parameter int WALK_T   = 10,
   localparam int PH_W    = $clog2(N_PHASE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic [N_PHASE-1:0] ped_req,
`ifdef NIGHT_FLASH_EN
   input  logic               night_mode,
`endif
   output logic [N_PHASE-1:0] red,
   output logic [N_PHASE-1:0] yellow,
   output logic [N_PHASE-1:0] green,
   output logic [N_PHASE-1:0] walk,
   output logic               dont_walk,
   output logic [PH_W-1:0]    phase,
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {
      S_CLEAR  = 3'd0,
      S_GREEN  = 3'd1,
      S_YELLOW = 3'd2,
      S_WALK   = 3'd3
`ifdef NIGHT_FLASH_EN
      , S_FLASH = 3'd4
`endif
   } state_t;

   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_T - 1);
   localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
   localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(N_PHASE - 1);
   localparam logic [N_PHASE-1:0] ALL_ONE = {N_PHASE{1'b1}};
   localparam logic [N_PHASE-1:0] ONE     = N_PHASE'(1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     timer_q, timer_d;
   logic [PH_W-1:0]      phase_q, phase_d;
   logic [N_PHASE-1:0]   ped_pend_q, ped_pend_d;
   logic [N_PHASE-1:0]   red_q, red_d;
   logic [N_PHASE-1:0]   yellow_q, yellow_d;
   logic [N_PHASE-1:0]   green_q, green_d;
   logic [N_PHASE-1:0]   walk_q, walk_d;
   logic                 dont_walk_q, dont_walk_d;
   logic                 expire;
   logic [N_PHASE-1:0]   req_all;
   logic [N_PHASE-1:0]   owner;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      phase_d    = phase_q;
      walk_d     = walk_q;
      ped_pend_d = ped_pend_q | ped_req;
      req_all    = ped_pend_q | ped_req;
      expire     = tick && (timer_q == '0);

      if (tick && (timer_q != '0)) begin
         timer_d = timer_q - 1'b1;
      end

      case (state_q)
         S_CLEAR: begin
            if (expire) begin
`ifdef NIGHT_FLASH_EN
               if (night_mode) begin
                  state_d = S_FLASH;
               end else
`endif
               begin
                  state_d = S_GREEN;
                  timer_d = GREEN_LD;
                  phase_d = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
               end
            end
         end
         S_GREEN: begin
            if (expire) begin
               state_d = S_YELLOW;
               timer_d = YELLOW_LD;
            end
         end
         S_YELLOW: begin
            if (expire) begin
               // Requests arriving on the expiry cycle itself are served in this WALK.
               if (|req_all) begin
                  state_d    = S_WALK;
                  timer_d    = WALK_LD;
                  walk_d     = req_all;
                  ped_pend_d = '0;
               end else begin
                  state_d = S_CLEAR;
                  timer_d = CLEAR_LD;
               end
            end
         end
         S_WALK: begin
            if (expire) begin
               state_d = S_CLEAR;
               timer_d = CLEAR_LD;
               walk_d  = '0;
            end
         end
`ifdef NIGHT_FLASH_EN
         S_FLASH: begin
            if (!night_mode) begin
               state_d = S_CLEAR;
               timer_d = CLEAR_LD;
            end
         end
`endif
         default: begin
            state_d = S_CLEAR;
            timer_d = CLEAR_LD;
            walk_d  = '0;
         end
      endcase

      // Lamp outputs are decoded from the next state so they flip on the same edge.
      owner       = ONE << phase_d;
      red_d       = ALL_ONE;
      yellow_d    = '0;
      green_d     = '0;
      case (state_d)
         S_GREEN: begin
            green_d = owner;
            red_d   = ~owner;
         end
         S_YELLOW: begin
            yellow_d = owner;
            red_d    = ~owner;
         end
`ifdef NIGHT_FLASH_EN
         S_FLASH: begin
            red_d = '0;
            if (state_q == S_FLASH) begin
               yellow_d = tick ? ~yellow_q : yellow_q;
            end
         end
`endif
         default: begin
            red_d = ALL_ONE;
         end
      endcase
      dont_walk_d = ~|walk_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_CLEAR;
         timer_q     <= CLEAR_LD;
         phase_q     <= LAST_PH;
         ped_pend_q  <= '0;
         red_q       <= ALL_ONE;
         yellow_q    <= '0;
         green_q     <= '0;
         walk_q      <= '0;
         dont_walk_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         phase_q     <= phase_d;
         ped_pend_q  <= ped_pend_d;
         red_q       <= red_d;
         yellow_q    <= yellow_d;
         green_q     <= green_d;
         walk_q      <= walk_d;
         dont_walk_q <= dont_walk_d;
      end
   end

   assign red       = red_q;
   assign yellow    = yellow_q;
   assign green     = green_q;
   assign walk      = walk_q;
   assign dont_walk = dont_walk_q;
   assign phase     = phase_q;
   assign dbg_state = state_q;

endmodule
